// File: rtl/fxpn_matmul_block.sv
// N x N sign-magnitude fixed-point matrix multiplier. A and B are streamed in
// one row per beat, an output-stationary MAC array forms C, and C drains row by row.
module fxpn_matmul_block #(
  parameter  int N    = 4,
  parameter  int DW   = 8,
  parameter  int FRAC = 3,
  localparam int BUSW = N * DW,
  localparam int ACCW = 2 * DW - 1 + $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en_in_data,
  output logic            rdy_in_data,
  input  logic            in_mat,
  input  logic            in_mat_done,
  input  logic [BUSW-1:0] in_data,
  output logic            en_out_data,
  input  logic            rdy_out_data,
  output logic            out_mat_done,
  output logic [BUSW-1:0] out_data
);
  localparam int              IW      = (N > 1) ? $clog2(N) : 1;
  localparam int              MW      = DW - 1;
  localparam logic [IW-1:0]   LAST    = IW'(N - 1);
  localparam logic [ACCW-1:0] MAX_MAG = ACCW'((1 << MW) - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

  state_t state, state_nxt;

  logic [IW-1:0]          row;
  logic [IW-1:0]          k;
  logic [IW-1:0]          q;
  logic                   pad_active;
  logic [DW-1:0]          a_buf [N][N];
  logic [DW-1:0]          b_buf [N][N];
  logic signed [ACCW-1:0] acc   [N][N];
  logic signed [ACCW-1:0] prod  [N][N];
  logic [ACCW-1:0]        abs_v [N];
  logic [ACCW-1:0]        shr_v [N];
  logic [MW-1:0]          mag_v [N];
  logic [BUSW-1:0]        c_row;

  logic accept, wr_en, load_end, out_fire, drain_end;

  // A beat for the wrong matrix simply sees rdy low and waits.
  assign rdy_in_data = rstn & ~pad_active &
                       (((state == LOAD_A) & ~in_mat) | ((state == LOAD_B) & in_mat));
  assign accept      = en_in_data & rdy_in_data;
  assign wr_en       = accept | pad_active;
  assign load_end    = wr_en & (row == LAST);
  assign en_out_data = (state == DRAIN);
  assign out_fire    = en_out_data & rdy_out_data;
  assign drain_end   = out_fire & (q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= LOAD_A;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD_A:  if (load_end)  state_nxt = LOAD_B;
      LOAD_B:  if (load_end)  state_nxt = COMPUTE;
      COMPUTE: if (k == LAST) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = LOAD_A;
      default:                state_nxt = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row        <= '0;
      pad_active <= 1'b0;
      k          <= '0;
      q          <= '0;
    end else begin
      if (load_end) begin
        row        <= '0;
        pad_active <= 1'b0;
      end else if (wr_en) begin
        row <= row + 1'b1;
        if (accept & in_mat_done) pad_active <= 1'b1;
      end
      if (state == COMPUTE) k <= (k == LAST) ? '0 : k + 1'b1;
      if (out_fire)         q <= (q == LAST) ? '0 : q + 1'b1;
    end
  end

  // NOTE: operand buffers have no reset; each load rewrites all N rows (padding included) before COMPUTE reads them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < N; j++) begin
        if (state == LOAD_B) b_buf[row][j] <= pad_active ? '0 : in_data[DW*(N-1-j) +: DW];
        else                 a_buf[row][j] <= pad_active ? '0 : in_data[DW*(N-1-j) +: DW];
      end
    end
  end

  // Signed partial products for step k; a zero magnitude yields zero whatever the sign bit.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j] = $signed(ACCW'(a_buf[i][k][MW-1:0]) * ACCW'(b_buf[k][j][MW-1:0]));
        if (a_buf[i][k][DW-1] ^ b_buf[k][j][DW-1]) prod[i][j] = -prod[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] <= '0;
    end else if (state == COMPUTE) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] <= acc[i][j] + prod[i][j];
    end else if (drain_end) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] <= '0;
    end
  end

  // Truncate toward zero, saturate the magnitude, and never emit negative zero.
  always_comb begin
    c_row = '0;
    for (int j = 0; j < N; j++) begin
      abs_v[j] = acc[q][j][ACCW-1] ? ACCW'(-acc[q][j]) : ACCW'(acc[q][j]);
      shr_v[j] = abs_v[j] >> FRAC;
      mag_v[j] = (shr_v[j] > MAX_MAG) ? MW'(MAX_MAG) : shr_v[j][MW-1:0];
      c_row[DW*(N-1-j) +: DW] = {acc[q][j][ACCW-1] & (mag_v[j] != '0), mag_v[j]};
    end
  end

  assign out_data     = en_out_data ? c_row : '0;
  assign out_mat_done = en_out_data & (q == LAST);

endmodule

// File: tb/tb_fxpn_matmul_block.sv
// Randomised bench for fxpn_matmul_block: an integer matrix model predicts every
// output row, and one monitor compares the DUT against it on every cycle.
module tb_fxpn_matmul_block;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int FRAC = 3;
  localparam int BUSW = N * DW;

  typedef logic [DW-1:0] mat_t [N][N];
  typedef struct {
    logic [BUSW-1:0] data;
    bit              last;
  } exp_row_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            en_in_data = 1'b0;
  logic            rdy_in_data;
  logic            in_mat = 1'b0;
  logic            in_mat_done = 1'b0;
  logic [BUSW-1:0] in_data = '0;
  logic            en_out_data;
  logic            rdy_out_data = 1'b0;
  logic            out_mat_done;
  logic [BUSW-1:0] out_data;

  fxpn_matmul_block #(.N(N), .DW(DW), .FRAC(FRAC)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en_in_data  (en_in_data),
    .rdy_in_data (rdy_in_data),
    .in_mat      (in_mat),
    .in_mat_done (in_mat_done),
    .in_data     (in_data),
    .en_out_data (en_out_data),
    .rdy_out_data(rdy_out_data),
    .out_mat_done(out_mat_done),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int              errors = 0;
  int              checks = 0;
  exp_row_t        exp_q[$];
  logic [BUSW-1:0] got_rows [N];
  int              row_idx = 0;
  int              out_mode = 0;
  bit              lat_armed = 0;
  int              exp_t = 0;

  task automatic check(input string name, input logic [BUSW-1:0] got, input logic [BUSW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int dec(input logic [DW-1:0] e);
    int m;
    m = int'(e[DW-2:0]);
    return e[DW-1] ? -m : m;
  endfunction

  function automatic logic [DW-1:0] enc(input int c);
    int m;
    logic [DW-1:0] r;
    m = ((c < 0) ? -c : c) / (1 << FRAC);
    if (m > (1 << (DW-1)) - 1) m = (1 << (DW-1)) - 1;
    r[DW-2:0] = m[DW-2:0];
    r[DW-1]   = (c < 0) && (m != 0);
    return r;
  endfunction

  function automatic logic [BUSW-1:0] pack(input mat_t m, input int i);
    logic [BUSW-1:0] d;
    for (int j = 0; j < N; j++) d[DW*(N-1-j) +: DW] = m[i][j];
    return d;
  endfunction

  // Monitor: drives consumer ready and checks every output cycle against the model queue.
  initial begin : monitor
    bit prev_en;
    bit prev_stalled;
    bit last_popped;
    int stall_cnt;
    logic [BUSW-1:0] prev_data;
    prev_en = 0; prev_stalled = 0; last_popped = 0; stall_cnt = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      #1;
      case (out_mode)
        1:       rdy_out_data = ($urandom_range(3) != 0);
        2:       rdy_out_data = (stall_cnt >= 3);
        default: rdy_out_data = 1'b1;
      endcase
      if (last_popped) begin
        check("rdy_in_after_drain", BUSW'(rdy_in_data), BUSW'(rstn & ~in_mat));
        last_popped = 0;
      end
      if (en_out_data) begin
        check("rdy_in_during_drain", BUSW'(rdy_in_data), '0);
        if (prev_stalled) check("held_row_stable", out_data, prev_data);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_row: got %h with no row outstanding", out_data);
        end else begin
          check("out_row", out_data, exp_q[0].data);
          check("out_mat_done", BUSW'(out_mat_done), BUSW'(exp_q[0].last));
          if (!prev_en && lat_armed) begin
            check("first_row_latency", BUSW'(cyc - exp_t), BUSW'(N));
            lat_armed = 0;
          end
          if (rdy_out_data) begin
            got_rows[row_idx] = out_data;
            row_idx     = exp_q[0].last ? 0 : row_idx + 1;
            last_popped = exp_q[0].last;
            void'(exp_q.pop_front());
            stall_cnt    = 0;
            prev_stalled = 0;
          end else begin
            stall_cnt++;
            prev_stalled = 1;
            prev_data    = out_data;
          end
        end
      end else begin
        check("idle_out_data", out_data, '0);
        check("idle_out_mat_done", BUSW'(out_mat_done), '0);
        prev_stalled = 0;
      end
      prev_en = en_out_data;
    end
  end

  task automatic send_row(input bit m, input bit done, input logic [BUSW-1:0] d, output int acc_q);
    int n;
    n = 0;
    acc_q = cyc;
    en_in_data = 1'b1; in_mat = m; in_mat_done = done; in_data = d;
    forever begin
      #2;
      if (rdy_in_data) begin
        acc_q = cyc;
        @(negedge clk);
        return;
      end
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL input_accept_timeout: row of matrix %0d never accepted", m);
        return;
      end
    end
  endtask

  task automatic run_pair(input mat_t a, input mat_t b, input int ar, input int br,
                          input bit done_full, input bit probe, input bit abort);
    mat_t az, bz;
    int q_last, s, n;
    exp_row_t e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        az[i][j] = (i < ar) ? a[i][j] : '0;
        bz[i][j] = (i < br) ? b[i][j] : '0;
      end
    if (probe) begin
      en_in_data = 1'b1; in_mat = 1'b1; in_mat_done = 1'b0; in_data = pack(b, 0);
      repeat (3) begin
        #2 check("b_stalled_in_load_a", BUSW'(rdy_in_data), '0);
        @(negedge clk);
      end
    end
    for (int r = 0; r < ar; r++)
      send_row(1'b0, (r == ar-1) && (ar < N || done_full), pack(a, r), q_last);
    if (probe && ar < N) begin
      en_in_data = 1'b1; in_mat = 1'b0; in_mat_done = 1'b0;
      for (int p = 0; p < N - ar; p++) begin
        #2 check("rdy_low_while_padding", BUSW'(rdy_in_data), '0);
        @(negedge clk);
      end
      in_mat = 1'b1;
      #2 check("rdy_high_in_load_b", BUSW'(rdy_in_data), BUSW'(1));
    end
    for (int r = 0; r < br; r++)
      send_row(1'b1, (r == br-1) && (br < N || done_full), pack(b, r), q_last);
    en_in_data = 1'b0; in_mat_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int kk = 0; kk < N; kk++) s += dec(az[i][kk]) * dec(bz[kk][j]);
        e.data[DW*(N-1-j) +: DW] = enc(s);
      end
      e.last = (i == N-1);
      exp_q.push_back(e);
    end
    exp_t = q_last + 1 + (N - br);
    lat_armed = 1;
    if (abort) begin
      repeat (2) @(negedge clk);
      en_in_data = 1'b1; in_mat = 1'b0;
      rstn = 1'b0;
      #1;
      check("abort_en_out_data", BUSW'(en_out_data), '0);
      check("abort_out_mat_done", BUSW'(out_mat_done), '0);
      check("abort_out_data", out_data, '0);
      check("abort_rdy_in_data", BUSW'(rdy_in_data), '0);
      exp_q.delete();
      lat_armed = 0;
      row_idx = 0;
      repeat (2) @(negedge clk);
      rstn = 1'b1; en_in_data = 1'b0;
      @(negedge clk);
      return;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d rows still outstanding", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  function automatic mat_t rand_mat(input int max_mag, input bit no_negzero);
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        m[i][j] = {1'($urandom_range(1)), 7'($urandom_range(max_mag))};
        if (no_negzero && m[i][j] == 8'h80) m[i][j] = 8'h00;
      end
    return m;
  endfunction

  initial begin : main
    mat_t a, b, ident;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) ident[i][j] = (i == j) ? 8'h08 : 8'h00;

    en_in_data = 1'b1; in_mat = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_rdy_in_data", BUSW'(rdy_in_data), '0);
    check("reset_en_out_data", BUSW'(en_out_data), '0);
    check("reset_out_mat_done", BUSW'(out_mat_done), '0);
    check("reset_out_data", out_data, '0);
    @(negedge clk);
    rstn = 1'b1; en_in_data = 1'b0;
    @(negedge clk);

    // Identity x B reproduces B.
    b = rand_mat(127, 1);
    b[0][0] = 8'h10; b[0][1] = 8'h88; b[0][2] = 8'h18; b[0][3] = 8'h00;
    run_pair(ident, b, N, N, 1, 0, 0);
    check("ident_row0_literal", got_rows[0], 32'h10881800);
    for (int i = 0; i < N; i++) check("ident_c_equals_b", got_rows[i], pack(b, i));

    // Saturation, positive and negative.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin a[i][j] = 8'h7F; b[i][j] = 8'h7F; end
    run_pair(a, b, N, N, 0, 0, 0);
    for (int i = 0; i < N; i++) check("sat_pos", got_rows[i], 32'h7F7F7F7F);
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) a[i][j] = 8'hFF;
    run_pair(a, b, N, N, 0, 0, 0);
    for (int i = 0; i < N; i++) check("sat_neg", got_rows[i], 32'hFFFFFFFF);

    // Signed product and truncation to positive zero.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin a[i][j] = 8'h00; b[i][j] = 8'h00; end
    a[0][0] = 8'h88; b[0][0] = 8'h18;
    run_pair(a, b, N, N, 0, 0, 0);
    check("neg_product", got_rows[0], 32'h98000000);
    a[0][0] = 8'h81; b[0][0] = 8'h01;
    run_pair(a, b, N, N, 0, 0, 0);
    check("trunc_to_pos_zero", got_rows[0], 32'h00000000);

    // Short A with zero padding, B offered early, consumer stalled 3 cycles per row.
    out_mode = 2;
    a = rand_mat(127, 0);
    b = rand_mat(127, 0);
    run_pair(a, b, 2, N, 0, 1, 0);
    check("pad_row2_zero", got_rows[2], '0);
    check("pad_row3_zero", got_rows[3], '0);

    // Randomised pairs: short matrices, negative zero, random backpressure.
    for (int t = 0; t < 16; t++) begin
      out_mode = int'($urandom_range(2));
      a = rand_mat((t % 2) ? 127 : 20, 0);
      b = rand_mat((t % 2) ? 127 : 20, 0);
      run_pair(a, b, int'($urandom_range(N, 1)), int'($urandom_range(N, 1)),
               1'($urandom_range(1)), 1'($urandom_range(1)), 0);
    end

    // Reset mid-COMPUTE, then a clean identity run.
    out_mode = 0;
    a = rand_mat(127, 0);
    b = rand_mat(127, 0);
    run_pair(a, b, N, N, 0, 0, 1);
    b = rand_mat(127, 1);
    run_pair(ident, b, N, N, 0, 0, 0);
    for (int i = 0; i < N; i++) check("post_abort_c_equals_b", got_rows[i], pack(b, i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fxpn_matmul_block.md
Name: fxpn_matmul_block

Overview:
- Parametrised successor of the 2x2 fixed-point sign-magnitude PE block. Computes C = A x B for N x N matrices.
- Operands are streamed in row by row over a valid/ready bus. An N x N output-stationary MAC array computes the result in N cycles, and C is streamed out row by row under backpressure.
- New behaviour: generic N/DW/FRAC, rounding and saturation, enforced A-then-B ordering, zero-padding of short matrices, and an end-of-matrix marker on output.

Parameters:
- N, 4: matrix dimension; bus carries one N-element row per beat.
- DW, 8: element width, sign-magnitude (bit DW-1 = sign, DW-2:0 = magnitude).
- FRAC, 3: fractional bits of magnitude (LSB weight 2^-FRAC).
- Derived, not overridable: BUSW = N*DW; ACCW = 2*DW-1+clog2(N) (signed two's-complement accumulator).

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- en_in_data  in  1  input beat valid.
- rdy_in_data  out  1  input beat accepted when en_in_data & rdy_in_data.
- in_mat  in  1  0 = beat is a row of A, 1 = row of B.
- in_mat_done  in  1  qualifies an accepted beat as the last supplied row of the current matrix.
- in_data  in  BUSW  row data; element j at bits [DW*(N-j)-1 : DW*(N-j-1)] (element 0 in MSBs).
- en_out_data  out  1  output row valid.
- rdy_out_data  in  1  consumer ready.
- out_mat_done  out  1  high with the last row (row N-1) of C.
- out_data  out  BUSW  row of C, same packing as in_data.

Behaviour:
- Reset (rstn low, asynchronous):
  - state = LOAD_A; row counters, k counter and all accumulators = 0.
  - en_out_data = 0, out_mat_done = 0, out_data = 0, rdy_in_data = 0 while rstn is low.
  - Reset mid-operation discards everything; the next matrix pair starts from A row 0.
- States: LOAD_A -> LOAD_B -> COMPUTE -> DRAIN -> LOAD_A.
- rdy_in_data = (state==LOAD_A & in_mat==0 | state==LOAD_B & in_mat==1) & ~pad_active.
  - A wrong-matrix beat is stalled, not dropped.
- Each accepted beat writes buffer row r of the current matrix and increments r.
  - At r = N-1, or on a beat with in_mat_done=1, the load of that matrix ends.
- Zero-pad: if in_mat_done=1 on a beat with r < N-1, rows r+1..N-1 are written with zero, one row per cycle.
  - pad_active is high for those N-1-r cycles and rdy_in_data is low.
  - After the last pad row, state advances (LOAD_A->LOAD_B, LOAD_B->COMPUTE).
- Input sign-magnitude negative zero is treated as zero.
- COMPUTE lasts exactly N cycles, k = 0..N-1.
  - Per cycle, every PE(i,j) does acc += sign(A[i][k]) x sign(B[k][j]) x |A[i][k]| x |B[k][j]|.
  - Product magnitude is 2*(DW-1) bits; the sign is the XOR of the operand signs.
- Latency: last B beat accepted (or last pad row) in cycle t -> COMPUTE t+1..t+N -> en_out_data high from cycle t+N+1.
- Result conversion per element:
  - mag = |acc| >> FRAC, truncated toward zero.
  - If mag > 2^(DW-1)-1, saturate to 2^(DW-1)-1.
  - sign = acc<0 & mag!=0, so no negative-zero output.
- DRAIN:
  - Output row index q starts at 0; out_data = converted row q; en_out_data = 1.
  - q advances only on en_out_data & rdy_out_data. out_data is held stable while stalled.
  - out_mat_done = en_out_data & (q==N-1).
  - On acceptance of row N-1: accumulators cleared, state = LOAD_A, en_out_data = 0 next cycle.
- out_data = 0 whenever en_out_data = 0.
- No input is accepted during COMPUTE or DRAIN (no double buffering).
- en_in_data may stay high across states; it is ignored outside the LOAD states.
- Simultaneous in_mat_done on the row N-1 beat: normal completion, no padding.

Test Plan:
- A = identity (diagonal 0x08 = 1.0, rest 0x00), B row0 = {0x10,0x88,0x18,0x00}, other rows arbitrary -> C row0 = {0x10,0x88,0x18,0x00}, C equals B; out_mat_done only on 4th output beat; first en_out_data exactly N+1 = 5 cycles after last B beat.
- A and B all 0x7F -> every C element 0x7F (saturated); A all 0xFF, B all 0x7F -> every C element 0xFF.
- A[0][0] = 0x88 (-1.0), B[0][0] = 0x18 (3.0), rest 0 -> C[0][0] = 0x98 (-3.0); A[0][0] = 0x81, B[0][0] = 0x01 -> C[0][0] = 0x00 (truncated, positive zero).
- Send 2 A rows with in_mat_done on row 1 -> rdy_in_data low for 2 cycles, A rows 2..3 zero; a B beat offered during A load is stalled until LOAD_B; C rows 2..3 = 0x00.
- Hold rdy_out_data low 3 cycles on each output row -> out_data stable, no rows lost or repeated, out_mat_done high only with row 3, rdy_in_data rises the cycle after row 3 is accepted.
- Assert rstn low mid-COMPUTE (k = 2) -> all outputs 0 immediately; after release, a fresh identity x B run yields C = B with no residue from the aborted run.
